sram_bank_ctrl: RTL

//  Owns port 0 (RW) of NUM_BANKS sky130_sram_2kbyte_1rw1r_32x512_8 macros.

---
 rtl/sram_ctrl_pkg.sv | 10 +
 rtl/sram_rr_arbiter.sv | 31 +++
 rtl/sram_bank_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM bank controller
package sram_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_WB, OWN_B} owner_t;

  localparam int          BANK_W        = 3;
  localparam logic [31:0] RDATA_INVALID = 32'h0;

endpackage

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - two-way round-robin arbiter (index 0 = WB, index 1 = B)
module sram_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // last_b: B owned the previously completed access; cur_b: owner of the access in flight
  logic last_b;
  logic cur_b;

  // On a tie the requester that did not win last time gets the grant
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_b ? 2'b01 : 2'b10;
  end

  // Remember the winner at grant time, commit it as last_grant when the access completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
      cur_b  <= 1'b0;
    end else begin
      if (gnt != 2'b00) cur_b <= gnt[1];
      if (advance) last_b <= cur_b;
    end
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - arbitrated, fixed-latency sequencer for port 0 of the SRAM banks
module sram_bank_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_BANKS = 5,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 1
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [31:0]                 wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_dat_o,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic [BANK_W-1:0]           req_bank_i,
  input  logic [ADDR_W-1:0]           req_addr_i,
  input  logic [DATA_W/8-1:0]         req_wmask_i,
  input  logic [DATA_W-1:0]           req_wdata_i,
  output logic                        rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic [NUM_BANKS-1:0]        sram_csb0_o,
  output logic                        sram_web0_o,
  output logic [DATA_W/8-1:0]         sram_wmask0_o,
  output logic [ADDR_W-1:0]           sram_addr0_o,
  output logic [DATA_W-1:0]           sram_din0_o,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_dout0_i
);

  localparam int MASK_W = DATA_W / 8;

  state_t            state;
  owner_t            owner;
  logic [BANK_W-1:0] bank_q;
  logic              we_q;
  logic [1:0]        wait_cnt;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              idle;
  logic [DATA_W-1:0] rd_word;
  logic              unused_adr_bits;

  assign unused_adr_bits = ^{wbs_adr_i[31:14], wbs_adr_i[1:0]};

  // Arbitration only happens while idle; everything else is locked out mid-access
  assign idle        = (state == IDLE);
  assign req         = {req_valid_i & idle, wbs_cyc_i & wbs_stb_i & idle};
  assign req_ready_o = wb_rst_ni & idle & gnt[1];

  sram_rr_arbiter u_arb (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .req     (req),
    .advance (state == DONE),
    .gnt     (gnt)
  );

  // One active-low select per bank; an out-of-range bank selects nothing
  function automatic logic [NUM_BANKS-1:0] csb_decode(input logic [BANK_W-1:0] bank);
    logic [NUM_BANKS-1:0] csb;
    for (int k = 0; k < NUM_BANKS; k++) csb[k] = (bank != BANK_W'(k));
    return csb;
  endfunction

  // Pick the addressed bank's read data; invalid banks read as a fixed constant
  always_comb begin
    rd_word = DATA_W'(RDATA_INVALID);
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (bank_q == BANK_W'(k)) rd_word = sram_dout0_i[k*DATA_W +: DATA_W];
    end
  end

  // Access sequencer: grant, issue one select cycle, wait out read latency, complete
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state         <= IDLE;
      owner         <= OWN_WB;
      bank_q        <= '0;
      we_q          <= 1'b0;
      wait_cnt      <= '0;
      sram_csb0_o   <= '1;
      sram_web0_o   <= 1'b1;
      sram_wmask0_o <= '0;
      sram_addr0_o  <= '0;
      sram_din0_o   <= '0;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
    end else begin
      wbs_ack_o   <= 1'b0;
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt[0]) begin
            owner         <= OWN_WB;
            bank_q        <= wbs_adr_i[13:11];
            we_q          <= wbs_we_i;
            sram_addr0_o  <= wbs_adr_i[2 +: ADDR_W];
            sram_wmask0_o <= MASK_W'(wbs_sel_i);
            sram_din0_o   <= DATA_W'(wbs_dat_i);
            sram_csb0_o   <= csb_decode(wbs_adr_i[13:11]);
            sram_web0_o   <= ~wbs_we_i;
            state         <= ISSUE;
          end else if (gnt[1]) begin
            owner         <= OWN_B;
            bank_q        <= req_bank_i;
            we_q          <= req_we_i;
            sram_addr0_o  <= req_addr_i;
            sram_wmask0_o <= req_wmask_i;
            sram_din0_o   <= req_wdata_i;
            sram_csb0_o   <= csb_decode(req_bank_i);
            sram_web0_o   <= ~req_we_i;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          sram_csb0_o <= '1;
          sram_web0_o <= 1'b1;
          wait_cnt    <= '0;
          if (we_q) begin
            wbs_ack_o   <= (owner == OWN_WB);
            rsp_valid_o <= (owner == OWN_B);
            state       <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'(READ_LAT - 1)) begin
            wbs_ack_o   <= (owner == OWN_WB);
            rsp_valid_o <= (owner == OWN_B);
            wbs_dat_o   <= (owner == OWN_WB) ? 32'(rd_word) : 32'h0;
            rsp_rdata_o <= (owner == OWN_B) ? rd_word : '0;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        DONE: begin
          wbs_dat_o   <= '0;
          rsp_rdata_o <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
